store_buffer: RTL
=================

Name: store_buffer

Overview:
- Committed-store buffer between the commit stage and the TCM store port.
- Accepts retired stores in program order and holds them in a circular FIFO.
- Drains one store per cycle onto the bus store-write channel. The drained fields are the ones the TCM consumes as bus_tcm_stbuf_write_addr, _size, the _data port (shared by reads and writes), and _wr.
- Provides same-cycle store-to-load byte forwarding so loads see stores that have not yet drained.

Parameters:
- STBUF_DEPTH, 8: number of entries. Must be a power of 2, ≥2.
- STBUF_PTR_WIDTH, $clog2(STBUF_DEPTH): index width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- commit_stbuf_valid  in  1  store push request
- commit_stbuf_addr  in  `ADDR_WIDTH  byte address
- commit_stbuf_size  in  `SIZE_WIDTH  bytes: 1, 2 or 4
- commit_stbuf_data  in  `REG_DATA_WIDTH  store data, LSB-aligned
- stbuf_commit_ready  out  1  buffer can accept a push this cycle
- stbuf_bus_write_addr  out  `ADDR_WIDTH  head entry address
- stbuf_bus_write_size  out  `SIZE_WIDTH  head entry size
- stbuf_bus_data  out  `REG_DATA_WIDTH  head entry data
- stbuf_bus_wr  out  1  head entry valid, write request
- bus_stbuf_write_ready  in  1  bus accepts the write this cycle
- lsu_stbuf_fwd_addr  in  `ADDR_WIDTH  load byte address
- lsu_stbuf_fwd_size  in  `SIZE_WIDTH  load size
- stbuf_lsu_fwd_data  out  `REG_DATA_WIDTH  forwarded bytes, LSB-aligned
- stbuf_lsu_fwd_mask  out  `REG_DATA_WIDTH/8  per-byte forward hit
- stbuf_empty  out  1  no valid entries (used by fence)

Behaviour:
- Storage:
  - STBUF_DEPTH entries, each {addr, size, data}; payload registers need no reset.
  - rptr and wptr are STBUF_PTR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = (rptr == wptr).
  - full = index bits equal and wrap bits differ.
- Reset: asynchronous on rst=1.
  - rptr=wptr=0.
  - Outputs become stbuf_bus_wr=0, stbuf_commit_ready=1, stbuf_empty=1, fwd_mask=0, fwd_data=0.
  - Reset mid-operation discards all entries, including any in-flight write that is not handshaken.
- Push:
  - push = commit_stbuf_valid && stbuf_commit_ready.
  - stbuf_commit_ready = !full. It is registered-state based, with no same-cycle bypass from pop.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - On push, write entry[wptr index] and increment wptr.
- Pop:
  - stbuf_bus_wr = !empty. The head fields are driven combinationally from entry[rptr index].
  - pop = stbuf_bus_wr && bus_stbuf_write_ready; on pop, increment rptr.
  - Head fields stay stable while stbuf_bus_wr=1 and ready=0.
- Simultaneous push and pop in a non-full, non-empty state: both pointers advance and the count is unchanged.
- Push into an empty buffer: stbuf_bus_wr rises the next cycle, so drain latency is 1 cycle.
- Wrap-around: pointer index bits roll from STBUF_DEPTH-1 to 0 and the wrap bit toggles.
- Illegal size (not 1/2/4): the entry is accepted and drained unchanged; it contributes no forwarding bytes.
- Forwarding (purely combinational, same cycle):
  - For each load byte k < lsu_stbuf_fwd_size, form byte address b = fwd_addr + k.
  - Search valid entries from youngest (wptr-1) to oldest (rptr).
  - The first entry with addr ≤ b < addr+size (unsigned, modulo `ADDR_WIDTH) supplies byte data[(b-addr)*8 +: 8] into fwd_data[k*8 +: 8] and sets fwd_mask[k].
  - Bytes with no hit have mask=0 and data=0; bytes with k ≥ load size have mask=0.
  - The head entry being popped this cycle still forwards.
  - An entry pushed this cycle is not visible until the next cycle.
  - The LSU merges fwd_data over the TCM read data using the mask.

Decomposition:
- Shared common package holds:
  - the stbuf_entry_t typedef {addr, size, data};
  - the size encodings SIZE_BYTE=1, SIZE_HALF=2, SIZE_WORD=4;
  - STBUF_DEPTH as a config define.
- Sub-module store_buffer_fwd_unit contains the per-byte youngest-match priority selection over the entry array plus valid vector. It is instantiated once, with a loop over load bytes inside it.
- The FIFO pointers and entry array stay in store_buffer.

Test Plan:
- Reset, then push {0x100, 4, 0xDEADBEEF} with ready=1 → next cycle wr=1, addr=0x100, size=4, data=0xDEADBEEF; cycle after, empty=1.
- Push 8 stores with ready=0 → stbuf_commit_ready=0 after the 8th. A 9th push with ready=1 in the same cycle is refused; the next cycle it is accepted.
- Bus ready held 0 for 5 cycles with 3 entries → head fields unchanged. Ready=1 for 3 cycles then drains in order; pointers wrap past index 7 correctly over 20 push/pop cycles.
- Stores {0x200,4,0x11223344} then {0x201,1,0xAA}; load 0x200 size 4 → mask=0xF, data=0x1122AA44.
- Store {0x302,2,0xBBCC}; load 0x300 size 4 → mask=0xC, data=0xBBCC0000. The same load with an empty buffer → mask=0.
- Assert rst asynchronously mid-cycle with 4 entries and wr=1 → wr drops immediately, empty=1, ready=1, no further writes.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types, widths and size encodings for the committed-store buffer.
// Width macros may be overridden by the including build; these are the defaults.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef STBUF_DEPTH
`define STBUF_DEPTH 8
`endif

package store_buffer_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int SIZE_W = `SIZE_WIDTH;
  localparam int DATA_W = `REG_DATA_WIDTH;
  localparam int NBYTES = `REG_DATA_WIDTH / 8;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] SIZE_HALF = SIZE_W'(2);
  localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] data;
  } stbuf_entry_t;

  function automatic logic size_is_legal(input logic [SIZE_W-1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
  endfunction

endpackage

// File: rtl/store_buffer_fwd_unit.sv
// Per-load-byte youngest-match selection over the store buffer entries.
// Ages are walked oldest to youngest so the last hit (the youngest) wins.
module store_buffer_fwd_unit
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  stbuf_entry_t      entries_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PW-1:0]     head_idx_i,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  input  logic [SIZE_W-1:0] fwd_size_i,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [NBYTES-1:0] fwd_mask_o
);

  logic [PW-1:0]     idx;
  logic [ADDR_W-1:0] byte_addr;
  logic [ADDR_W-1:0] offset;

  always_comb begin
    fwd_data_o = '0;
    fwd_mask_o = '0;
    idx        = '0;
    byte_addr  = '0;
    offset     = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (SIZE_W'(k) < fwd_size_i) begin
        byte_addr = fwd_addr_i + ADDR_W'(k);
        for (int j = 0; j < DEPTH; j++) begin
          idx    = head_idx_i + PW'(j);
          // Modular difference makes a single unsigned compare cover the range check.
          offset = byte_addr - entries_i[idx].addr;
          if (valid_i[idx] && size_is_legal(entries_i[idx].size) &&
              (offset < ADDR_W'(entries_i[idx].size))) begin
            fwd_mask_o[k]         = 1'b1;
            fwd_data_o[k*8 +: 8]  = entries_i[idx].data[{offset[1:0], 3'b000} +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO between commit and the TCM store port, with
// same-cycle store-to-load byte forwarding for stores not yet drained.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int STBUF_DEPTH = `STBUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit_stbuf_valid,
  input  logic [ADDR_W-1:0]       commit_stbuf_addr,
  input  logic [SIZE_W-1:0]       commit_stbuf_size,
  input  logic [DATA_W-1:0]       commit_stbuf_data,
  output logic                    stbuf_commit_ready,
  output logic [ADDR_W-1:0]       stbuf_bus_write_addr,
  output logic [SIZE_W-1:0]       stbuf_bus_write_size,
  output logic [DATA_W-1:0]       stbuf_bus_data,
  output logic                    stbuf_bus_wr,
  input  logic                    bus_stbuf_write_ready,
  input  logic [ADDR_W-1:0]       lsu_stbuf_fwd_addr,
  input  logic [SIZE_W-1:0]       lsu_stbuf_fwd_size,
  output logic [DATA_W-1:0]       stbuf_lsu_fwd_data,
  output logic [NBYTES-1:0]       stbuf_lsu_fwd_mask,
  output logic                    stbuf_empty
);

  localparam int STBUF_PTR_WIDTH = $clog2(STBUF_DEPTH);
  localparam int PW = STBUF_PTR_WIDTH;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds while valid && !ready.
  logic [PW:0]        rptr_q, rptr_d, wptr_q, wptr_d;
  stbuf_entry_t       entries_q [STBUF_DEPTH];
  logic               full, push, pop;
  logic [PW:0]        count;
  logic [PW-1:0]      rel;
  logic [STBUF_DEPTH-1:0] valid;

  assign stbuf_empty        = (rptr_q == wptr_q);
  assign full               = (rptr_q[PW-1:0] == wptr_q[PW-1:0]) && (rptr_q[PW] != wptr_q[PW]);
  assign stbuf_commit_ready = !full;
  assign push               = commit_stbuf_valid && stbuf_commit_ready;
  assign stbuf_bus_wr       = !stbuf_empty;
  assign pop                = stbuf_bus_wr && bus_stbuf_write_ready;
  assign rptr_d             = pop  ? rptr_q + 1'b1 : rptr_q;
  assign wptr_d             = push ? wptr_q + 1'b1 : wptr_q;
  assign count              = wptr_q - rptr_q;

  assign stbuf_bus_write_addr = entries_q[rptr_q[PW-1:0]].addr;
  assign stbuf_bus_write_size = entries_q[rptr_q[PW-1:0]].size;
  assign stbuf_bus_data       = entries_q[rptr_q[PW-1:0]].data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wptr_q[PW-1:0]] <= '{addr: commit_stbuf_addr,
                                     size: commit_stbuf_size,
                                     data: commit_stbuf_data};
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    rel   = '0;
    for (int i = 0; i < STBUF_DEPTH; i++) begin
      rel      = PW'(i) - rptr_q[PW-1:0];
      valid[i] = ({1'b0, rel} < count);
    end
  end

  store_buffer_fwd_unit #(
    .DEPTH (STBUF_DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries_i  (entries_q),
    .valid_i    (valid),
    .head_idx_i (rptr_q[PW-1:0]),
    .fwd_addr_i (lsu_stbuf_fwd_addr),
    .fwd_size_i (lsu_stbuf_fwd_size),
    .fwd_data_o (stbuf_lsu_fwd_data),
    .fwd_mask_o (stbuf_lsu_fwd_mask)
  );

endmodule
